int_bypass_network: RTL

//  Parametrised integer forwarding network for the core pipeline. Tracks in-flight

---
 rtl/int_bypass_network_pkg.sv | 24 ++
 rtl/int_bypass_network_if.sv | 35 +++
 rtl/int_bypass_network_read_port.sv | 55 +++++
 rtl/int_bypass_network.sv | 99 +++++++++
 4 files changed

// File: rtl/int_bypass_network_pkg.sv
// Shared types for the integer bypass network: the in-flight entry layout
// and the match rule used by every read port.
`ifndef XLEN
`define XLEN 32
`endif

package bypass_pkg;

    localparam int XLEN = `XLEN;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            data_ok;
    } bypass_entry_t;

    // x0 is hardwired, so it can never be a forwarding source.
    function automatic logic entry_matches(bypass_entry_t e, logic [4:0] sel);
        return e.valid && (sel != REG_ZERO) && (e.rd == sel);
    endfunction

endpackage

// File: rtl/int_bypass_network_if.sv
// Pipeline-side bus of the bypass network: producer, late fill, decode read
// ports and the register-file write.
interface int_bypass_network_if #(
    parameter int XLEN     = bypass_pkg::XLEN,
    parameter int NUM_READ = 2
);
    logic                     advance;
    logic                     flush;
    logic                     prod_valid;
    logic [4:0]               prod_rd;
    logic [XLEN-1:0]          prod_data;
    logic                     prod_data_ok;
    logic                     fill_valid;
    logic [XLEN-1:0]          fill_data;
    logic [NUM_READ*5-1:0]    rs_sel;
    logic [NUM_READ*XLEN-1:0] rf_data;
    logic [NUM_READ*XLEN-1:0] rs_data;
    logic [NUM_READ-1:0]      rs_fwd;
    logic                     stall;
    logic                     wb_valid;
    logic [4:0]               wb_rd;
    logic [XLEN-1:0]          wb_data;

    modport master (
        output advance, flush, prod_valid, prod_rd, prod_data, prod_data_ok,
               fill_valid, fill_data, rs_sel, rf_data,
        input  rs_data, rs_fwd, stall, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  advance, flush, prod_valid, prod_rd, prod_data, prod_data_ok,
               fill_valid, fill_data, rs_sel, rf_data,
        output rs_data, rs_fwd, stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/int_bypass_network_read_port.sv
// One decode read port: youngest-match priority over the in-flight entries,
// with a same-cycle bypass of late load data arriving at LOAD_STAGE.
module bypass_read_port
    import bypass_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1
) (
    input  bypass_entry_t   ent [DEPTH],
    input  logic            fill_valid,
    input  logic [XLEN-1:0] fill_data,
    input  logic [4:0]      sel,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] data,
    output logic            fwd,
    output logic            hazard
);

    logic            hit;
    logic            hit_ok;
    logic            hit_load;
    logic [XLEN-1:0] hit_data;

    always_comb begin
        hit      = 1'b0;
        hit_ok   = 1'b0;
        hit_load = 1'b0;
        hit_data = '0;
        // Scan oldest to youngest so the youngest match overwrites.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entry_matches(ent[k], sel)) begin
                hit      = 1'b1;
                hit_ok   = ent[k].data_ok;
                hit_load = (k == LOAD_STAGE);
                hit_data = ent[k].data;
            end
        end

        data   = rf_data;
        fwd    = 1'b0;
        hazard = 1'b0;
        if (hit) begin
            if (hit_load && fill_valid && !hit_ok) begin
                data = fill_data;
                fwd  = 1'b1;
            end else if (hit_ok) begin
                data = hit_data;
                fwd  = 1'b1;
            end else begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_bypass_network.sv
// Integer forwarding network: DEPTH-stage queue of in-flight results between
// execute and writeback, feeding NUM_READ decode ports and the rf write.
module int_bypass_network
    import bypass_pkg::*;
#(
    parameter int XLEN       = bypass_pkg::XLEN,
    parameter int DEPTH      = 3,
    parameter int NUM_READ   = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    int_bypass_network_if.slave   bus
);

    localparam logic LOAD_AT_RETIRE = (LOAD_STAGE == DEPTH - 1);

    bypass_entry_t   ent [DEPTH];
    bypass_entry_t   load_ent;
    logic            fill_hit;
    logic            retire_ok;
    logic [XLEN-1:0] port_data [NUM_READ];
    logic            port_fwd  [NUM_READ];
    logic            hazard    [NUM_READ];
    logic            any_hazard;

    // Entry at LOAD_STAGE as it looks once this cycle's fill is applied.
    always_comb begin
        fill_hit = bus.fill_valid && ent[LOAD_STAGE].valid && !ent[LOAD_STAGE].data_ok;
        load_ent = ent[LOAD_STAGE];
        if (fill_hit) begin
            load_ent.data    = bus.fill_data;
            load_ent.data_ok = 1'b1;
        end
    end

    // Only the valid bits are reset; payload is qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) ent[k].valid <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) ent[k].valid <= 1'b0;
        end else if (bus.advance) begin
            ent[0] <= '{valid:   bus.prod_valid && (bus.prod_rd != REG_ZERO),
                        rd:      bus.prod_rd,
                        data:    bus.prod_data,
                        data_ok: bus.prod_data_ok};
            for (int k = 1; k < DEPTH; k++) begin
                ent[k] <= (k - 1 == LOAD_STAGE) ? load_ent : ent[k-1];
            end
        end else begin
            ent[LOAD_STAGE] <= load_ent;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        bypass_read_port #(
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_port (
            .ent        (ent),
            .fill_valid (bus.fill_valid),
            .fill_data  (bus.fill_data),
            .sel        (bus.rs_sel[i*5 +: 5]),
            .rf_data    (bus.rf_data[i*XLEN +: XLEN]),
            .data       (port_data[i]),
            .fwd        (port_fwd[i]),
            .hazard     (hazard[i])
        );
    end

    always_comb begin
        bus.rs_data = '0;
        bus.rs_fwd  = '0;
        any_hazard  = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            bus.rs_data[i*XLEN +: XLEN] = port_data[i];
            bus.rs_fwd[i]               = port_fwd[i];
            any_hazard                  = any_hazard | hazard[i];
        end
    end

    // A load at the retire slot can still be completed by a fill this cycle.
    assign retire_ok    = LOAD_AT_RETIRE ? load_ent.data_ok : ent[DEPTH-1].data_ok;
    assign bus.wb_valid = bus.advance && !bus.flush && ent[DEPTH-1].valid &&
                          (ent[DEPTH-1].rd != REG_ZERO);
    assign bus.wb_rd    = ent[DEPTH-1].rd;
    assign bus.wb_data  = LOAD_AT_RETIRE ? load_ent.data : ent[DEPTH-1].data;
    assign bus.stall    = any_hazard || (ent[DEPTH-1].valid && !retire_ok);

    a_no_advance_in_stall : assert property (
        @(posedge clk) disable iff (rst) !(bus.advance && bus.stall))
        else $error("int_bypass_network: advance asserted while stalled");

    a_retire_has_data : assert property (
        @(posedge clk) disable iff (rst) !(bus.wb_valid && !retire_ok))
        else $error("int_bypass_network: retiring an entry without data");

endmodule
